// File: rtl/uart_rx_fifo_pkg.sv
// Shared definitions for the UART receive FIFO: peripheral address indices,
// default depth and the pull FSM state type.
package uart_rx_fifo_pkg;

  localparam logic [3:0] PERI_UART_FIFO      = 4'hD;
  localparam logic [3:0] PERI_UART_FIFO_CTRL = 4'hE;

  localparam int unsigned UART_FIFO_DEPTH_LOG2 = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PULL = 2'd1,
    ST_HOLD = 2'd2
  } pull_state_t;

  function automatic int unsigned fifo_depth(input int unsigned depth_log2);
    return 32'd1 << depth_log2;
  endfunction

endpackage

// File: rtl/uart_rx_fifo_byte_fifo.sv
// Byte FIFO with show-ahead head, one-bit-wider level so full and empty are
// distinct; flush clears pointers and level and beats push/pop.
module byte_fifo
  import uart_rx_fifo_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = UART_FIFO_DEPTH_LOG2
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  push,
  input  logic [7:0]            push_data,
  input  logic                  pop,
  input  logic                  flush,
  output logic [7:0]            rd_data,
  output logic                  rd_valid,
  output logic                  full,
  output logic [DEPTH_LOG2:0]   level
);

  localparam int unsigned        DEPTH      = fifo_depth(DEPTH_LOG2);
  localparam logic [DEPTH_LOG2:0] LEVEL_FULL = (DEPTH_LOG2+1)'(DEPTH);

  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q;
  logic [DEPTH_LOG2-1:0] rd_ptr_q;
  logic [DEPTH_LOG2:0]   level_q;
  logic                  push_ok;
  logic                  pop_ok;

  assign rd_valid = (level_q != '0);
  assign full     = (level_q == LEVEL_FULL);
  assign push_ok  = push && !full;
  assign pop_ok   = pop && rd_valid;

  // Storage is deliberately left unreset; rd_data is masked while empty.
  always_ff @(posedge clk) begin
    if (push_ok && !flush) begin
      mem[wr_ptr_q] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr_q <= wr_ptr_q + (DEPTH_LOG2)'(1);
      end
      if (pop_ok) begin
        rd_ptr_q <= rd_ptr_q + (DEPTH_LOG2)'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   level_q <= level_q + (DEPTH_LOG2+1)'(1);
        2'b01:   level_q <= level_q - (DEPTH_LOG2+1)'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  assign rd_data = rd_valid ? mem[rd_ptr_q] : 8'h00;
  assign level   = level_q;

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive buffer between uart_rx and the CPU read mux: pulls bytes from
// uart_rx into a byte FIFO and raises irq once the level reaches a threshold.
//
// state | meaning
// IDLE  | waiting for uart_rx_valid with room in the FIFO
// PULL  | uart_rx_read pulse, byte written into the FIFO
// HOLD  | dead cycle while uart_rx drops valid
module uart_rx_fifo
  import uart_rx_fifo_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = UART_FIFO_DEPTH_LOG2
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  uart_rx_valid,
  input  logic [7:0]            uart_rx_data,
  output logic                  uart_rx_read,
  input  logic                  pop,
  input  logic                  flush,
  input  logic                  set_threshold,
  input  logic [DEPTH_LOG2:0]   threshold_in,
  output logic [7:0]            rd_data,
  output logic                  rd_valid,
  output logic                  full,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  irq
);

  pull_state_t         state_q;
  pull_state_t         state_d;
  logic                push;
  logic [DEPTH_LOG2:0] threshold_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // full comes from the registered level, so a pop this cycle cannot open a pull.
  always_comb begin
    state_d = state_q;
    push    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (uart_rx_valid && !full && !flush) begin
          state_d = ST_PULL;
        end
      end
      ST_PULL: begin
        push    = 1'b1;
        state_d = ST_HOLD;
      end
      ST_HOLD: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign uart_rx_read = push;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      threshold_q <= '0;
    end else if (set_threshold) begin
      threshold_q <= threshold_in;
    end
  end

  assign irq = (threshold_q != '0) && (level >= threshold_q);

  byte_fifo #(
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clk       (clk),
    .rstn      (rstn),
    .push      (push),
    .push_data (uart_rx_data),
    .pop       (pop),
    .flush     (flush),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .full      (full),
    .level     (level)
  );

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: a queue-based reference model with an
// intake timeline (one accepted byte per three cycles) and a byte source.
module tb_uart_rx_fifo;

  localparam int DEPTH_LOG2 = 3;
  localparam int DEPTH      = 1 << DEPTH_LOG2;

  logic                clk = 1'b0;
  logic                rstn;
  logic                uart_rx_valid;
  logic [7:0]          uart_rx_data;
  logic                uart_rx_read;
  logic                pop;
  logic                flush;
  logic                set_threshold;
  logic [DEPTH_LOG2:0] threshold_in;
  logic [7:0]          rd_data;
  logic                rd_valid;
  logic                full;
  logic [DEPTH_LOG2:0] level;
  logic                irq;

  always #5 clk = ~clk;

  uart_rx_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) dut (
    .clk           (clk),
    .rstn          (rstn),
    .uart_rx_valid (uart_rx_valid),
    .uart_rx_data  (uart_rx_data),
    .uart_rx_read  (uart_rx_read),
    .pop           (pop),
    .flush         (flush),
    .set_threshold (set_threshold),
    .threshold_in  (threshold_in),
    .rd_data       (rd_data),
    .rd_valid      (rd_valid),
    .full          (full),
    .level         (level),
    .irq           (irq)
  );

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] mq[$];
  logic [7:0] src[$];
  int         m_thr;
  bit         m_pull;
  int         m_ready;
  int         cyc;
  int         pulses;

  function automatic logic [DEPTH_LOG2:0] exp_level();
    return (DEPTH_LOG2+1)'(mq.size());
  endfunction

  function automatic logic [7:0] exp_data();
    return (mq.size() != 0) ? mq[0] : 8'h00;
  endfunction

  function automatic logic exp_irq();
    return (m_thr != 0) && (mq.size() >= m_thr);
  endfunction

  task automatic model_reset();
    mq.delete();
    src.delete();
    m_thr   = 0;
    m_pull  = 1'b0;
    m_ready = cyc;
  endtask

  // Reference behaviour at a rising edge, using the inputs held this cycle.
  task automatic model_edge();
    int sz;
    bit pulled;
    sz     = mq.size();
    pulled = m_pull;
    if (flush) begin
      mq.delete();
    end else begin
      if (pop && sz > 0) void'(mq.pop_front());
      if (pulled) mq.push_back(uart_rx_data);
    end
    if (set_threshold) m_thr = int'(threshold_in);
    m_pull = 1'b0;
    if (cyc >= m_ready && uart_rx_valid && sz < DEPTH && !flush) begin
      m_pull  = 1'b1;
      m_ready = cyc + 3;
    end
    cyc++;
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic tick();
    logic rd_now;
    uart_rx_valid = (src.size() != 0);
    uart_rx_data  = (src.size() != 0) ? src[0] : 8'h00;
    #1;
    rd_now = uart_rx_read;
    @(posedge clk);
    model_edge();
    if (rd_now) begin
      pulses++;
      if (src.size() != 0) void'(src.pop_front());
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rstn = 1'b0; pop = 1'b0; flush = 1'b0; set_threshold = 1'b0; threshold_in = '0;
    uart_rx_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      uart_rx_data = 8'($urandom);
      @(negedge clk);
      n_vec++; if (uart_rx_read !== 1'b0) begin n_err++; $display("FAIL reset_read: got %b want 0", uart_rx_read); end
      n_vec++; if (level !== '0) begin n_err++; $display("FAIL reset_level: got %0d want 0", level); end
      n_vec++; if (rd_valid !== 1'b0) begin n_err++; $display("FAIL reset_rd_valid: got %b want 0", rd_valid); end
      n_vec++; if (rd_data !== 8'h00) begin n_err++; $display("FAIL reset_rd_data: got %h want 00", rd_data); end
      n_vec++; if (irq !== 1'b0 || full !== 1'b0) begin n_err++; $display("FAIL reset_irq_full: got %b%b want 00", irq, full); end
    end
    uart_rx_valid = 1'b0;
    rstn = 1'b1;
    model_reset();
  endtask

  task automatic test_single();
    src.push_back(8'hA5);
    pulses = 0;
    repeat (8) begin
      tick();
      n_vec++; if (uart_rx_read !== m_pull) begin n_err++; $display("FAIL single_read: got %b want %b", uart_rx_read, m_pull); end
      n_vec++; if (level !== exp_level()) begin n_err++; $display("FAIL single_level: got %0d want %0d", level, exp_level()); end
    end
    n_vec++; if (pulses != 1) begin n_err++; $display("FAIL single_pulses: got %0d want 1", pulses); end
    n_vec++; if (rd_data !== 8'hA5 || level !== 4'd1) begin n_err++; $display("FAIL single_head: got %h/%0d want a5/1", rd_data, level); end
    pop = 1'b1; tick(); pop = 1'b0;
    n_vec++; if (level !== '0 || rd_valid !== 1'b0) begin n_err++; $display("FAIL single_pop: got %0d/%b want 0/0", level, rd_valid); end
  endtask

  task automatic test_fill();
    logic [7:0] e;
    for (int i = 1; i <= 9; i++) src.push_back(8'(i));
    pulses = 0;
    repeat (40) begin
      tick();
      n_vec++; if (uart_rx_read !== m_pull) begin n_err++; $display("FAIL fill_read: got %b want %b", uart_rx_read, m_pull); end
      n_vec++; if (full !== (mq.size() == DEPTH)) begin n_err++; $display("FAIL fill_full: got %b want %b", full, mq.size() == DEPTH); end
    end
    n_vec++; if (pulses != 8 || src.size() != 1) begin n_err++; $display("FAIL fill_pulses: got %0d pulses %0d left want 8/1", pulses, src.size()); end
    n_vec++; if (full !== 1'b1 || level !== 4'd8) begin n_err++; $display("FAIL fill_full_level: got %b/%0d want 1/8", full, level); end
    for (int i = 0; i < 8; i++) begin
      e = 8'(i + 1);
      n_vec++; if (rd_data !== e) begin n_err++; $display("FAIL fill_order: got %h want %h", rd_data, e); end
      pop = 1'b1; tick(); pop = 1'b0;
    end
    repeat (6) tick();
    n_vec++; if (rd_data !== 8'h09 || level !== 4'd1) begin n_err++; $display("FAIL fill_ninth: got %h/%0d want 09/1", rd_data, level); end
    pop = 1'b1; tick(); pop = 1'b0;
  endtask

  task automatic test_wrap();
    logic [7:0] sent[$];
    logic [7:0] got[$];
    for (int i = 0; i < 20; i++) sent.push_back(8'($urandom));
    src = sent;
    repeat (80) begin
      pop = uart_rx_read;
      if (pop && rd_valid) got.push_back(rd_data);
      tick();
      n_vec++; if (level > 4'd1 || level !== exp_level()) begin n_err++; $display("FAIL wrap_level: got %0d want %0d (<=1)", level, exp_level()); end
    end
    pop = 1'b0;
    got.push_back(rd_data);
    pop = 1'b1; tick(); pop = 1'b0;
    n_vec++; if (got.size() != 20) begin n_err++; $display("FAIL wrap_count: got %0d want 20", got.size()); end
    for (int i = 0; i < 20 && i < got.size(); i++) begin
      n_vec++; if (got[i] !== sent[i]) begin n_err++; $display("FAIL wrap_order[%0d]: got %h want %h", i, got[i], sent[i]); end
    end
  endtask

  task automatic test_threshold();
    set_threshold = 1'b1; threshold_in = 4'd3; tick(); set_threshold = 1'b0;
    src.push_back(8'h11); src.push_back(8'h22);
    repeat (8) tick();
    n_vec++; if (irq !== 1'b0 || level !== 4'd2) begin n_err++; $display("FAIL thr_two: got irq %b lvl %0d want 0/2", irq, level); end
    src.push_back(8'h33);
    repeat (4) tick();
    n_vec++; if (irq !== 1'b1) begin n_err++; $display("FAIL thr_three: got %b want 1", irq); end
    pop = 1'b1; tick(); pop = 1'b0;
    n_vec++; if (irq !== 1'b0) begin n_err++; $display("FAIL thr_pop: got %b want 0", irq); end
    for (int i = 0; i < 6; i++) src.push_back(8'($urandom));
    repeat (20) tick();
    n_vec++; if (level !== 4'd8 || irq !== 1'b1) begin n_err++; $display("FAIL thr_full: got %0d/%b want 8/1", level, irq); end
    set_threshold = 1'b1; threshold_in = '0; tick(); set_threshold = 1'b0;
    n_vec++; if (irq !== 1'b0) begin n_err++; $display("FAIL thr_zero: got %b want 0", irq); end
    flush = 1'b1; tick(); flush = 1'b0;
  endtask

  task automatic test_flush();
    bit found;
    int p0;
    found = 1'b0;
    for (int i = 0; i < 6; i++) src.push_back(8'($urandom));
    for (int i = 0; i < 40 && !found; i++) begin
      tick();
      if (level == 4'd5 && uart_rx_read) found = 1'b1;
    end
    n_vec++; if (!found) begin n_err++; $display("FAIL flush_setup: got timeout want level 5 in PULL"); end
    p0 = pulses;
    flush = 1'b1; tick(); flush = 1'b0;
    n_vec++; if (level !== '0 || rd_valid !== 1'b0) begin n_err++; $display("FAIL flush_clear: got %0d/%b want 0/0", level, rd_valid); end
    n_vec++; if (pulses != p0 + 1 || src.size() != 0) begin n_err++; $display("FAIL flush_pulse: got %0d pulses want %0d", pulses - p0, 1); end
    src.push_back(8'h3C);
    repeat (5) tick();
    n_vec++; if (rd_data !== 8'h3C || level !== 4'd1) begin n_err++; $display("FAIL flush_next: got %h/%0d want 3c/1", rd_data, level); end
    pop = 1'b1; repeat (3) tick(); pop = 1'b0;
    n_vec++; if (level !== '0 || rd_valid !== 1'b0) begin n_err++; $display("FAIL flush_pop_empty: got %0d/%b want 0/0", level, rd_valid); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 2) == 0 && src.size() < 4) src.push_back(8'($urandom));
      pop           = ($urandom_range(0, 3) == 0);
      flush         = ($urandom_range(0, 39) == 0);
      set_threshold = ($urandom_range(0, 24) == 0);
      threshold_in  = (DEPTH_LOG2+1)'($urandom_range(0, DEPTH));
      tick();
      n_vec++; if (uart_rx_read !== m_pull) begin n_err++; $display("FAIL rand_read: got %b want %b", uart_rx_read, m_pull); end
      n_vec++; if (level !== exp_level()) begin n_err++; $display("FAIL rand_level: got %0d want %0d", level, exp_level()); end
      n_vec++; if (rd_valid !== (mq.size() != 0)) begin n_err++; $display("FAIL rand_rd_valid: got %b want %b", rd_valid, mq.size() != 0); end
      n_vec++; if (rd_data !== exp_data()) begin n_err++; $display("FAIL rand_rd_data: got %h want %h", rd_data, exp_data()); end
      n_vec++; if (full !== (mq.size() == DEPTH)) begin n_err++; $display("FAIL rand_full: got %b want %b", full, mq.size() == DEPTH); end
      n_vec++; if (irq !== exp_irq()) begin n_err++; $display("FAIL rand_irq: got %b want %b", irq, exp_irq()); end
    end
    pop = 1'b0; flush = 1'b0; set_threshold = 1'b0;
  endtask

  task automatic test_reset_mid_pull();
    bit found;
    found = 1'b0;
    src.delete();
    flush = 1'b1; tick(); flush = 1'b0;
    src.push_back(8'h77);
    for (int i = 0; i < 10 && !found; i++) begin
      tick();
      if (uart_rx_read) found = 1'b1;
    end
    n_vec++; if (!found) begin n_err++; $display("FAIL midpull_setup: got timeout want read pulse"); end
    #2 rstn = 1'b0;
    #1;
    n_vec++; if (uart_rx_read !== 1'b0 || level !== '0) begin n_err++; $display("FAIL midpull_reset: got %b/%0d want 0/0", uart_rx_read, level); end
    @(negedge clk);
    rstn = 1'b1;
    model_reset();
    src.push_back(8'h5A);
    repeat (5) tick();
    n_vec++; if (rd_data !== 8'h5A || level !== 4'd1) begin n_err++; $display("FAIL midpull_after: got %h/%0d want 5a/1", rd_data, level); end
  endtask

  initial begin
    cyc = 0;
    pulses = 0;
    test_reset();
    test_single();
    test_fill();
    test_wrap();
    test_threshold();
    test_flush();
    test_random();
    test_reset_mid_pull();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
